// File: rtl/audio_pkg.sv
// Shared audio front-end types and helpers.
package audio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } dc_est_state_t;

    localparam int unsigned SAT_MAX_W = 32;

    typedef logic signed [SAT_MAX_W:0]   sat_wide_t;
    typedef logic signed [SAT_MAX_W-1:0] sat_narrow_t;

    // Clamp a (w+1)-bit signed difference, sign-extended to SAT_MAX_W+1, into w bits.
    function automatic sat_narrow_t sat_trunc(input sat_wide_t d, input int unsigned w);
        sat_wide_t hi;
        sat_wide_t lo;
        hi = (sat_wide_t'(1) <<< (w - 1)) - sat_wide_t'(1);
        lo = -(sat_wide_t'(1) <<< (w - 1));
        if (d > hi) begin
            return sat_narrow_t'(hi);
        end else if (d < lo) begin
            return sat_narrow_t'(lo);
        end else begin
            return sat_narrow_t'(d);
        end
    endfunction

endpackage

// File: rtl/sat_sub.sv
// Registered saturating subtractor y <= sat(a - b), updated only when en is high.
module sat_sub
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    audio_clk,
    input  logic                    rst_in,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH:0] diff;
    sat_wide_t             diff_wide;

    always_comb begin
        diff      = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        diff_wide = sat_wide_t'(diff);
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            y <= '0;
        end else if (en) begin
            y <= WIDTH'(sat_trunc(diff_wide, WIDTH));
        end
    end

endmodule

// File: rtl/dc_offset_estimator.sv
// Per-channel DC offset estimator over a 2^LOG2_N sample window with saturating live correction.
module dc_offset_estimator
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned LOG2_N   = 15
) (
    input  logic                      audio_clk,
    input  logic                      rst_in,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] audio_in,
    input  logic                      start,
    input  logic                      continuous,
    output logic [CHANNELS*WIDTH-1:0] offset,
    output logic                      offset_valid,
    output logic                      busy,
    output logic [CHANNELS*WIDTH-1:0] corrected_out,
    output logic                      corrected_valid
);

    localparam int unsigned ACC_W = WIDTH + LOG2_N;

    dc_est_state_t     state_q;
    dc_est_state_t     state_d;
    logic [LOG2_N-1:0] count_q;
    logic              accept_start;
    logic              accum_sample;
    logic              window_end;

    // Next-state and window-control decode.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        accum_sample = 1'b0;
        window_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    accum_sample = 1'b1;
                    if (&count_q) begin
                        window_end = 1'b1;
                        state_d    = continuous ? ACCUM : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shared sample counter and status flags.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            count_q         <= '0;
            busy            <= 1'b0;
            offset_valid    <= 1'b0;
            corrected_valid <= 1'b0;
        end else begin
            if (accept_start || window_end) begin
                count_q <= '0;
            end else if (accum_sample) begin
                count_q <= count_q + LOG2_N'(1);
            end
            busy            <= (state_d == ACCUM);
            offset_valid    <= window_end;
            corrected_valid <= sample_valid;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [WIDTH-1:0] sample;
        logic signed [ACC_W-1:0] sum_q;
        logic signed [ACC_W-1:0] sum_next;
        logic signed [ACC_W-1:0] mean;
        logic signed [WIDTH-1:0] off_q;
        logic signed [WIDTH-1:0] corr;

        always_comb begin
            sample   = audio_in[c*WIDTH +: WIDTH];
            sum_next = sum_q + ACC_W'(sample);
            mean     = sum_next >>> LOG2_N;
        end

        // Window-end sample is folded into the mean before the sum clears.
        always_ff @(posedge audio_clk) begin
            if (rst_in) begin
                sum_q <= '0;
                off_q <= '0;
            end else begin
                if (accept_start || window_end) begin
                    sum_q <= '0;
                end else if (accum_sample) begin
                    sum_q <= sum_next;
                end
                if (window_end) begin
                    off_q <= WIDTH'(mean);
                end
            end
        end

        sat_sub #(
            .WIDTH(WIDTH)
        ) u_sat_sub (
            .audio_clk(audio_clk),
            .rst_in   (rst_in),
            .en       (sample_valid),
            .a        (sample),
            .b        (off_q),
            .y        (corr)
        );

        assign offset[c*WIDTH +: WIDTH]        = off_q;
        assign corrected_out[c*WIDTH +: WIDTH] = corr;
    end

endmodule

// File: tb/tb_dc_offset_estimator.sv
// Directed scoreboard bench for dc_offset_estimator (WIDTH=16, CHANNELS=2, N=16).
module tb_dc_offset_estimator;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned LOG2_N   = 4;
    localparam int          N        = 16;

    logic                      audio_clk = 1'b0;
    logic                      rst_in;
    logic                      sample_valid;
    logic [CHANNELS*WIDTH-1:0] audio_in;
    logic                      start;
    logic                      continuous;
    logic [CHANNELS*WIDTH-1:0] offset;
    logic                      offset_valid;
    logic                      busy;
    logic [CHANNELS*WIDTH-1:0] corrected_out;
    logic                      corrected_valid;

    dc_offset_estimator #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .LOG2_N  (LOG2_N)
    ) dut (
        .audio_clk      (audio_clk),
        .rst_in         (rst_in),
        .sample_valid   (sample_valid),
        .audio_in       (audio_in),
        .start          (start),
        .continuous     (continuous),
        .offset         (offset),
        .offset_valid   (offset_valid),
        .busy           (busy),
        .corrected_out  (corrected_out),
        .corrected_valid(corrected_valid)
    );

    always #5 audio_clk = ~audio_clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] corr_q[$];
    logic [31:0] off_q[$];

    // Reference model state
    bit m_busy;
    int m_cnt;
    int m_sum0, m_sum1;
    int m_off0, m_off1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int d);
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
    endfunction

    task automatic step();
        @(posedge audio_clk);
        #1;
    endtask

    // One cycle of stimulus with the model updated for the coming edge.
    task automatic cyc(input bit sv, input int c0, input int c1, input bit st);
        int n0, n1;
        sample_valid = sv;
        start        = st;
        audio_in     = {16'(c1), 16'(c0)};
        if (sv) corr_q.push_back({16'(sat16(c1 - m_off1)), 16'(sat16(c0 - m_off0))});
        if (st && !m_busy) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_sum0 = 0;
            m_sum1 = 0;
        end else if (m_busy && sv) begin
            m_sum0 += c0;
            m_sum1 += c1;
            if (m_cnt == N - 1) begin
                n0 = m_sum0 >>> LOG2_N;
                n1 = m_sum1 >>> LOG2_N;
                off_q.push_back({16'(n1), 16'(n0)});
                m_off0 = n0;
                m_off1 = n1;
                m_cnt  = 0;
                m_sum0 = 0;
                m_sum1 = 0;
                if (!continuous) m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        step();
        sample_valid = 1'b0;
        start        = 1'b0;
        check("busy", 64'(busy), 64'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        m_sum0 = 0;
        m_sum1 = 0;
        m_off0 = 0;
        m_off1 = 0;
        check("rst_offset", 64'(offset), 64'd0);
        check("rst_offset_valid", 64'(offset_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_corrected", 64'(corrected_out), 64'd0);
        check("rst_corrected_valid", 64'(corrected_valid), 64'd0);
    endtask

    // Output monitor: each valid pulse pops its expected value.
    always @(negedge audio_clk) begin
        if (corrected_valid) begin
            check("corr_expected", 64'(corr_q.size() > 0), 64'd1);
            if (corr_q.size() > 0) check("corrected_out", 64'(corrected_out), 64'(corr_q.pop_front()));
        end
        if (offset_valid) begin
            check("offset_expected", 64'(off_q.size() > 0), 64'd1);
            if (off_q.size() > 0) check("offset", 64'(offset), 64'(off_q.pop_front()));
        end
    end

    int gap_off;

    initial begin
        rst_in       = 1'b1;
        sample_valid = 1'b0;
        start        = 1'b0;
        continuous   = 1'b0;
        audio_in     = '0;
        do_reset();

        // One-shot window: ch0=100, ch1=-37
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < N; i++) cyc(1'b1, 100, -37, 1'b0);
        check("oneshot_pulse", 64'(offset_valid), 64'd1);
        check("oneshot_busy_fall", 64'(busy), 64'd0);
        check("oneshot_offset", 64'(offset), {32'd0, 16'hFFDB, 16'd100});
        idle(2);
        check("offset_hold", 64'(offset), {32'd0, 16'hFFDB, 16'd100});

        // Floor rounding; start arrives with a strobe that must not be counted
        cyc(1'b1, 5000, 5000, 1'b1);
        for (int i = 0; i < N; i++) cyc(1'b1, (i % 2 == 0) ? 1 : 2, -1, 1'b0);
        check("floor_offset", 64'(offset), {32'd0, 16'hFFFF, 16'd1});
        idle(1);

        // Saturation: calibrate ch0=-100, ch1=100 then push extremes
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < N; i++) cyc(1'b1, -100, 100, 1'b0);
        idle(1);
        cyc(1'b1, 32767, 0, 1'b0);
        check("sat_hi", 64'(corrected_out[15:0]), 64'(16'h7FFF));
        check("sat_latency", 64'(corrected_valid), 64'd1);
        cyc(1'b1, 0, -32768, 1'b0);
        check("sat_lo", 64'(corrected_out[31:16]), 64'(16'h8000));
        check("sat_zero", 64'(corrected_out[15:0]), 64'd100);
        idle(2);
        check("corr_hold", 64'(corrected_valid), 64'd0);

        // Continuous: three back-to-back windows 10/20/30, continuous dropped in the third
        continuous = 1'b1;
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3 * N; i++) begin
            if (i == 2 * N + 4) continuous = 1'b0;
            cyc(1'b1, 10 * (i / N + 1), -10 * (i / N + 1), 1'b0);
        end
        check("cont_offset3", 64'(offset), {32'd0, 16'hFFE2, 16'd30});
        for (int i = 0; i < 20; i++) cyc(1'b1, 7, 7, 1'b0);
        check("cont_no_fourth", 64'(busy), 64'd0);

        // Start pulses mid-window and on the window-end cycle are ignored
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 300, 50, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 300, 50, 1'b0);
        cyc(1'b1, 300, 50, 1'b1);
        check("midstart_pulse", 64'(offset_valid), 64'd1);
        check("midstart_offset", 64'(offset), {32'd0, 16'd50, 16'd300});
        idle(1);

        // Random gaps between strobes give the gap-free answer
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            idle(int'($urandom_range(0, 5)));
            cyc(1'b1, (i % 2 == 0) ? 1 : 2, -1, 1'b0);
        end
        gap_off = int'(offset);
        check("gap_offset", 64'(offset), {32'd0, 16'hFFFF, 16'd1});
        idle(1);

        // Reset mid-window aborts it; a fresh window needs the full 16 strobes
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1000, 1000, 1'b0);
        do_reset();
        idle(2);
        cyc(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < N - 1; i++) cyc(1'b1, -64, 64, 1'b0);
        check("post_reset_no_early", 64'(offset_valid), 64'd0);
        cyc(1'b1, -64, 64, 1'b0);
        check("post_reset_pulse", 64'(offset_valid), 64'd1);
        check("post_reset_offset", 64'(offset), {32'd0, 16'd64, 16'hFFC0});
        idle(3);

        check("corr_queue_drained", 64'(corr_q.size()), 64'd0);
        check("offset_queue_drained", 64'(off_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_offset_estimator.md
# dc_offset_estimator

Multi-channel DC offset estimator and corrector for the audio front end. On a start pulse it averages a power-of-two window of valid samples per channel and publishes one signed offset per channel. It can re-estimate back-to-back in continuous mode, and it subtracts the current offsets from the live stream with saturation. It sits between the ADC/I2S sample source and the downstream DSP chain.

## Interface
Parameters:
- `WIDTH`, default 16: signed sample width per channel.
- `CHANNELS`, default 2: number of independent channels. Minimum 1.
- `LOG2_N`, default 15: window length is N = 2^LOG2_N samples. Range 1..20.

Ports:
- `audio_clk`  in  1: sole clock.
- `rst_in`  in  1: synchronous, active-high reset.
- `sample_valid`  in  1: one-cycle strobe; `audio_in` is valid on this cycle.
- `audio_in`  in  CHANNELS*WIDTH: packed signed samples, channel c at bits [c*WIDTH +: WIDTH].
- `start`  in  1: begin an estimation window. Ignored while `busy`.
- `continuous`  in  1: 1 = start a new window right after each one ends. Sampled at each window end.
- `offset`  out  CHANNELS*WIDTH: packed signed offsets, same packing as `audio_in`.
- `offset_valid`  out  1: one-cycle pulse when `offset` updates.
- `busy`  out  1: high while a window is accumulating.
- `corrected_out`  out  CHANNELS*WIDTH: saturated `audio_in - offset` per channel.
- `corrected_valid`  out  1: registered copy of `sample_valid`.

## Operation
- States:
  - IDLE: no window in progress.
  - ACCUM: a window is accumulating.
- Transitions:
  - IDLE -> ACCUM on `start`. Sums and count are cleared.
  - In ACCUM, each `sample_valid` adds every channel's sample to that channel's sum and increments the shared count.
- Window end is the sample on which count == N-1 (the Nth sample). On that same cycle:
  - Each offset register loads (sum + sample) >>> LOG2_N.
  - Sums and count clear.
  - `offset_valid` is set.
  - If `continuous` = 1, the block stays in ACCUM; otherwise it goes to IDLE.
- No samples are dropped between back-to-back windows.
- Arithmetic:
  - Accumulators are signed, WIDTH+LOG2_N bits, and cannot overflow.
  - The division is an arithmetic shift, i.e. floor. The result always fits in WIDTH bits.
- Offsets hold their value in IDLE until the next window completes. They are not cleared at window start.
- Correction path, every cycle for every channel: `corrected_out` <= sat(audio_in - offset).
  - The subtraction uses the `offset` value registered before this edge.
  - The difference is computed at WIDTH+1 bits and clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - `corrected_out` updates only when `sample_valid` is high; it holds otherwise.
- `start` asserted in ACCUM, including on the window-end cycle, is ignored.
- `start` in IDLE together with `sample_valid`: that sample is not counted. Counting begins on the next cycle.
- Reset mid-window aborts the window. No `offset_valid` pulse is produced.

## Timing
- Reset values: `offset` = 0, `offset_valid` = 0, `busy` = 0, `corrected_out` = 0, `corrected_valid` = 0. State = IDLE, sums = 0, count = 0.
- `busy` is high from the cycle after `start` until the cycle after a non-continuous window end.
- `offset_valid` is high exactly one cycle: the cycle after the Nth sample's edge. `offset` is stable from that cycle.
- Correction latency: 1 cycle from `sample_valid` to `corrected_valid`. An offset update takes effect on the first sample after `offset_valid`.
- Gaps between `sample_valid` strobes of any length are allowed. Strobes on consecutive cycles are allowed.

## Structure
- Shared package `audio_pkg` holds:
  - the `dc_est_state_t` enum (IDLE, ACCUM);
  - a `sat_trunc` function for (WIDTH+1)-to-WIDTH clamping.
- Sub-module `sat_sub` (parameter `WIDTH`): a registered saturating subtractor with enable. It is instantiated per channel by a generate loop.
- The estimator FSM and counter live in the top module. Per-channel accumulators are a generate array.

## Test plan
Bench configuration: WIDTH=16, CHANNELS=2, LOG2_N=4 (N=16).
- One-shot: `start`, then 16 strobes with ch0=100, ch1=-37, `continuous`=0 -> single `offset_valid` pulse one cycle after the 16th strobe; `offset` = {-37, 100}; `busy` falls on the same cycle.
- Floor rounding: ch0 alternating 1/2 (sum 24), ch1 constant -1 -> offset ch0 = 1, ch1 = -1 (not 0).
- Saturation: calibrate ch0 = -100 and ch1 = 100 -> input ch0 = 32767 gives 32767; input ch1 = -32768 gives -32768; input ch0 = 0 gives 100. All with `corrected_valid` one cycle after the strobe.
- Continuous: `continuous`=1, 48 consecutive strobes with window values 10, 20, 30 -> three `offset_valid` pulses with offsets 10, 20, 30. Drop `continuous` during the third window -> IDLE after the third pulse, no fourth window.
- Robustness:
  - `start` pulsed mid-window -> ignored; window length unchanged.
  - Random gaps of 0-5 cycles between strobes -> same offsets as the gap-free run.
  - `rst_in` after 9 strobes -> all outputs 0, `busy` 0, no `offset_valid`. A new `start` then needs a full 16 strobes.
